// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package mips_pkg;

  typedef enum logic [1:0] {
    RK_NONE   = 2'b00,
    RK_BRANCH = 2'b01,
    RK_JUMP   = 2'b10,
    RK_JR     = 2'b11
  } redirect_kind_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DROP = 2'b10
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between fetch and memory.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Small synchronous FIFO holding fetched {instr, pc4} pairs, with flush.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_r <= AW'(0);
      wr_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_r[wr_ptr_r] <= push_data;
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: PC, imem req/ack sequencing, fetch queue and redirect handling.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_fetch_unit_if.master        imem,
  input  logic                      stall,
  input  logic [1:0]                redirect_kind,
  input  logic [31:0]               redirect_pc4,
  input  logic [31:0]               redirect_imm,
  input  logic [31:0]               redirect_reg,
  output logic [31:0]               Instructions,
  output logic [31:0]               instr_pc4,
  output logic                      instr_valid
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_t  state_r, state_nxt_s;
  logic [31:0]   pc_r, pc_nxt_s;
  logic [31:0]   tgt_r, tgt_nxt_s;
  logic [31:0]   target_s;
  logic          redirect_s, push_s, pop_s;
  logic          room_idle_s, room_req_s;
  logic [CW-1:0] count_s;
  logic [CW:0]   base_s;
  logic [63:0]   head_s;

  assign redirect_s = (redirect_kind != 2'b00);
  assign pop_s      = instr_valid && !stall && !redirect_s;

  // Occupancy after this cycle's pop, with and without a push.
  assign base_s      = {1'b0, count_s} - {{CW{1'b0}}, pop_s};
  assign room_idle_s = (base_s < (CW+1)'(QDEPTH));
  assign room_req_s  = (base_s < (CW+1)'(QDEPTH - 1));

  // Redirect target for the resolved control-flow kind.
  always_comb begin
    target_s = 32'h0000_0000;
    case (redirect_kind_t'(redirect_kind))
      RK_BRANCH: target_s = redirect_pc4 + (redirect_imm << 2);
      RK_JUMP:   target_s = {redirect_pc4[31:28], redirect_imm[25:0], 2'b00};
      RK_JR:     target_s = redirect_reg & 32'hFFFF_FFFC;
      default:   target_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic; pc_r is the address of the current/next request and
  // tgt_r parks a redirect target while a wrong-path request drains.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    tgt_nxt_s   = tgt_r;
    push_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (redirect_s) begin
          pc_nxt_s    = target_s;
          state_nxt_s = REQ;
        end else if (room_idle_s) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (redirect_s) begin
          if (imem.imem_ack) begin
            pc_nxt_s    = target_s;
            state_nxt_s = REQ;
          end else begin
            tgt_nxt_s   = target_s;
            state_nxt_s = DROP;
          end
        end else if (imem.imem_ack) begin
          push_s      = 1'b1;
          pc_nxt_s    = pc_r + PC_STEP;
          state_nxt_s = room_req_s ? REQ : IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      DROP: begin
        if (imem.imem_ack) begin
          pc_nxt_s    = redirect_s ? target_s : tgt_r;
          state_nxt_s = REQ;
        end else if (redirect_s) begin
          tgt_nxt_s   = target_s;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, PC and parked-target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      tgt_r   <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      tgt_r   <= tgt_nxt_s;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH), .WIDTH(64)) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_s),
    .push      (push_s),
    .push_data ({imem.imem_rdata, pc_r + PC_STEP}),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (count_s)
  );

  assign imem.imem_req  = (state_r != IDLE);
  assign imem.imem_addr = pc_r;
  assign instr_valid    = (count_s != CW'(0));
  assign Instructions   = instr_valid ? head_s[63:32] : NOP_INSTR;
  assign instr_pc4      = instr_valid ? head_s[31:0]  : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed timing cases plus a randomized run
// scored against a program-order stream model and a memory model.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [1:0]  redirect_kind;
  logic [31:0] redirect_pc4, redirect_imm, redirect_reg;
  logic [31:0] Instructions, instr_pc4;
  logic        instr_valid;

  instr_fetch_unit_if imem_bus();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem_bus.master),
    .stall         (stall),
    .redirect_kind (redirect_kind),
    .redirect_pc4  (redirect_pc4),
    .redirect_imm  (redirect_imm),
    .redirect_reg  (redirect_reg),
    .Instructions  (Instructions),
    .instr_pc4     (instr_pc4),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        s_req, s_ack, s_valid;
  logic [31:0] s_addr, s_instr, s_pc4;

  logic [31:0] exp_next, hold_addr, data_mask;
  bit          hold_pend, redir_prev, rand_lat;
  int          mem_wait, mem_lat, idle_cnt, consumed;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [1:0] k, input logic [31:0] pc4,
                                             input logic [31:0] imm, input logic [31:0] rg);
    case (k)
      2'b01:   return pc4 + imm * 32'd4;
      2'b10:   return (pc4 & 32'hF000_0000) + (imm % 32'h0400_0000) * 32'd4;
      2'b11:   return (rg / 32'd4) * 32'd4;
      default: return pc4;
    endcase
  endfunction

  // One clock: drive memory at the falling edge, sample and score, then
  // advance the memory/stream model with what the rising edge saw.
  task automatic cycle();
    bit took;
    @(negedge clk);
    imem_bus.imem_ack   = imem_bus.imem_req && (mem_wait >= mem_lat);
    imem_bus.imem_rdata = imem_bus.imem_ack ? (imem_bus.imem_addr ^ data_mask) : 32'hBAD0_BAD0;
    #1;
    s_req = imem_bus.imem_req;  s_ack = imem_bus.imem_ack;  s_addr = imem_bus.imem_addr;
    s_valid = instr_valid;      s_instr = Instructions;     s_pc4 = instr_pc4;
    took = 1'b0;
    if (!rst) begin
      if (redir_prev) check_eq("flush_valid", 32'(s_valid), 32'd0);
      if (hold_pend) begin
        check_eq("hold_req", 32'(s_req), 32'd1);
        check_eq("hold_addr", s_addr, hold_addr);
      end
      check_eq("addr_align", s_addr & 32'h3, 32'd0);
      if (s_valid) begin
        check_eq("instr_data", s_instr, (s_pc4 - 32'd4) ^ data_mask);
        check_eq("stream_order", s_pc4 - 32'd4, exp_next);
        if (redirect_kind == 2'b00 && !stall) begin
          exp_next = s_pc4;
          consumed++;
          took = 1'b1;
          check_eq("progress_gap", 32'(idle_cnt <= 12), 32'd1);
          idle_cnt = 0;
        end
      end else begin
        check_eq("nop_instr", s_instr, NOP_INSTR);
        check_eq("nop_pc4", s_pc4, 32'd0);
      end
      if (redirect_kind != 2'b00) begin
        exp_next = ref_target(redirect_kind, redirect_pc4, redirect_imm, redirect_reg);
        idle_cnt = 0;
      end else if (!took && !stall) begin
        idle_cnt++;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      exp_next = RESET_PC; hold_pend = 1'b0; redir_prev = 1'b0; mem_wait = 0; idle_cnt = 0;
    end else begin
      redir_prev = (redirect_kind != 2'b00);
      hold_pend  = s_req && !s_ack;
      hold_addr  = s_addr;
      if (s_req && s_ack) begin
        mem_wait = 0;
        if (rand_lat) mem_lat = $urandom_range(0, 3);
      end else if (s_req) mem_wait++;
      else mem_wait = 0;
    end
  endtask

  task automatic set_redirect(input logic [1:0] k, input logic [31:0] pc4,
                              input logic [31:0] imm, input logic [31:0] rg);
    redirect_kind = k; redirect_pc4 = pc4; redirect_imm = imm; redirect_reg = rg;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] head_x, old_addr;
    bit          saw_ack;
    rst = 1'b1; stall = 1'b0;
    set_redirect(2'b00, 32'd0, 32'd0, 32'd0);
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'd0;
    exp_next = RESET_PC; hold_addr = 32'd0; data_mask = 32'd0;
    hold_pend = 1'b0; redir_prev = 1'b0; rand_lat = 1'b0;
    mem_wait = 0; mem_lat = 0; idle_cnt = 0; consumed = 0;

    // Reset values and first-fetch timing with zero-wait memory.
    cycle(); cycle();
    check_eq("rst_req", 32'(s_req), 32'd0);
    check_eq("rst_addr", s_addr, RESET_PC);
    check_eq("rst_valid", 32'(s_valid), 32'd0);
    check_eq("rst_instr", s_instr, 32'd0);
    check_eq("rst_pc4", s_pc4, 32'd0);
    rst = 1'b0;
    cycle(); check_eq("c0_req", 32'(s_req), 32'd0);
    cycle(); check_eq("c1_req", 32'(s_req), 32'd1); check_eq("c1_addr", s_addr, RESET_PC);
    cycle(); check_eq("c2_valid", 32'(s_valid), 32'd1); check_eq("c2_instr", s_instr, 32'h0);
             check_eq("c2_pc4", s_pc4, 32'h4); check_eq("c2_addr", s_addr, 32'h4);
    cycle(); check_eq("c3_instr", s_instr, 32'h4); check_eq("c3_pc4", s_pc4, 32'h8);
    cycle(); check_eq("c4_instr", s_instr, 32'h8); check_eq("c4_pc4", s_pc4, 32'hC);

    // Stall for three cycles: queue fills, requests stop, head holds.
    stall = 1'b1;
    cycle(); head_x = s_pc4;
    cycle(); cycle();
    check_eq("stall_req", 32'(s_req), 32'd0);
    check_eq("stall_head", s_pc4, head_x);
    stall = 1'b0;
    repeat (4) cycle();

    // Branch back by two words from pc4=0x100.
    set_redirect(2'b01, 32'h0000_0100, 32'hFFFF_FFFE, 32'd0);
    cycle(); set_redirect(2'b00, 32'd0, 32'd0, 32'd0);
    cycle(); check_eq("br_addr", s_addr, 32'h0000_00F8); check_eq("br_valid", 32'(s_valid), 32'd0);
    cycle(); check_eq("br_instr", s_instr, 32'h0000_00F8); check_eq("br_pc4", s_pc4, 32'h0000_00FC);

    // Jump coinciding with an ack, then a jump to the top word to check wrap.
    set_redirect(2'b10, 32'h1000_0010, 32'h0000_0040, 32'd0);
    cycle(); check_eq("jmp_ack_same", 32'(s_ack), 32'd1);
    set_redirect(2'b00, 32'd0, 32'd0, 32'd0);
    cycle(); check_eq("jmp_addr", s_addr, 32'h1000_0100);
    cycle(); check_eq("jmp_instr", s_instr, 32'h1000_0100);
    set_redirect(2'b10, 32'hF000_0000, 32'h03FF_FFFF, 32'd0);
    cycle(); set_redirect(2'b00, 32'd0, 32'd0, 32'd0);
    cycle(); check_eq("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    cycle(); check_eq("wrap_addr1", s_addr, 32'h0000_0000);
             check_eq("wrap_instr", s_instr, 32'hFFFF_FFFC); check_eq("wrap_pc4", s_pc4, 32'h0);
    cycle();

    // jr while a 3-wait request is outstanding.
    mem_lat = 3;
    for (int i = 0; i < 20; i++) begin
      if (imem_bus.imem_req && mem_wait == 1) break;
      cycle();
    end
    check_eq("jr_setup", 32'(imem_bus.imem_req && mem_wait == 1), 32'd1);
    old_addr = imem_bus.imem_addr;
    set_redirect(2'b11, 32'd0, 32'd0, 32'h0000_2003);
    cycle(); set_redirect(2'b00, 32'd0, 32'd0, 32'd0);
    cycle(); check_eq("jr_hold_addr", s_addr, old_addr); check_eq("jr_hold_req", 32'(s_req), 32'd1);
    saw_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (s_ack) begin saw_ack = 1'b1; break; end
      cycle();
    end
    check_eq("jr_old_ack", 32'(saw_ack), 32'd1);
    cycle(); check_eq("jr_addr", s_addr, 32'h0000_2000); check_eq("jr_req", 32'(s_req), 32'd1);
    mem_lat = 0;
    repeat (8) cycle();

    // Reset while a zero-wait request is being acknowledged.
    rst = 1'b1;
    cycle(); check_eq("rst_mid_ack", 32'(s_ack), 32'd1);
    cycle();
    check_eq("rst2_req", 32'(s_req), 32'd0); check_eq("rst2_valid", 32'(s_valid), 32'd0);
    check_eq("rst2_instr", s_instr, 32'd0);  check_eq("rst2_addr", s_addr, RESET_PC);
    rst = 1'b0;
    cycle(); check_eq("rr0_req", 32'(s_req), 32'd0);
    cycle(); check_eq("rr1_addr", s_addr, RESET_PC); check_eq("rr1_req", 32'(s_req), 32'd1);
    cycle(); check_eq("rr2_pc4", s_pc4, RESET_PC + 32'd4);

    // Randomized run: variable latency, stalls, redirects and rare resets.
    rst = 1'b1; data_mask = 32'hC3A5_5A3C; rand_lat = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        redirect_kind = 2'($urandom_range(1, 3));
        redirect_pc4  = $urandom() & 32'hFFFF_FFFC;
        redirect_imm  = (redirect_kind == 2'b01) ? (32'($urandom_range(0, 63)) - 32'd32) : $urandom();
        redirect_reg  = $urandom();
      end else begin
        redirect_kind = 2'b00;
      end
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0; stall = 1'b0; set_redirect(2'b00, 32'd0, 32'd0, 32'd0);
    repeat (20) cycle();
    check_eq("final_progress", 32'(consumed > 800), 32'd1);
    check_eq("final_idle", 32'(idle_cnt <= 12), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
